spi_axi_lite_reg_bridge: RTL
============================

# spi_axi_lite_reg_bridge

Downstream of the SPI slave's AXI-lite master port. Terminates AXI-lite and converts each transaction into one access on a simple valid/ready register bus that feeds the chip's peripheral register files. Serialises reads and writes, and alternates priority between them when both are pending. A timeout counter guarantees that every AXI-lite transaction gets a response, even if the register target never answers.

## Interface

Parameters:
- `AXI_ADDR_WIDTH`, default 32: address width on both sides.
- `AXI_DATA_WIDTH`, default 32: data width; strobe is `AXI_DATA_WIDTH/8`.
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles a register access may wait for `reg_ready_i`; must be ≥ 1.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `aw_valid_i`/`aw_addr_i`/`aw_ready_o`: AXI-lite write-address channel (1/`AXI_ADDR_WIDTH`/1).
- `w_valid_i`/`w_data_i`/`w_strb_i`/`w_ready_o`: write-data channel.
- `b_valid_o`/`b_resp_o` (2 bits)/`b_ready_i`: write-response channel.
- `ar_valid_i`/`ar_addr_i`/`ar_ready_o`: read-address channel.
- `r_valid_o`/`r_data_o`/`r_resp_o` (2 bits)/`r_ready_i`: read-data channel.
- `reg_valid_o` out 1: register access request.
- `reg_write_o` out 1: 1 = write, 0 = read.
- `reg_addr_o` out `AXI_ADDR_WIDTH`: access address.
- `reg_wdata_o` out `AXI_DATA_WIDTH`: write data.
- `reg_wstrb_o` out `AXI_DATA_WIDTH/8`: byte strobes.
- `reg_ready_i` in 1: the target has completed the access.
- `reg_rdata_i` in `AXI_DATA_WIDTH`: read data; sampled when `reg_ready_i` is high.
- `reg_error_i` in 1: error flag; sampled when `reg_ready_i` is high.

## Operation

- **Latching.** AW and W are captured independently into holding registers, each with its own valid flag.
  - `aw_ready_o` = state==IDLE && !aw_held.
  - `w_ready_o` = state==IDLE && !w_held.
  - `ar_ready_o` = state==IDLE && !ar_held.
- **States:** IDLE, REG_WR, REG_RD, RESP_B, RESP_R.
- **IDLE.** A write is pending when aw_held && w_held. A read is pending when ar_held.
  - If both are pending, serve the class not served last (a `last_was_write` flag, reset value 0, so the first contention goes to the write).
  - Otherwise serve whichever class is pending.
- **Zero-strobe write** (`w_strb` all 0): no bus access; go directly to RESP_B with OKAY.
- **REG_WR / REG_RD.**
  - `reg_valid_o` = 1, with address, data and strobe from the holding registers; the request is stable until it completes.
  - On `reg_ready_i`: capture `reg_rdata_i` (reads) and set resp = `reg_error_i` ? SLVERR (2'b10) : OKAY (2'b00).
  - Next state is RESP_B or RESP_R; clear the served holding flags.
- **Timeout.**
  - The counter clears on entry to REG_WR/REG_RD and increments every cycle without `reg_ready_i`.
  - When it reaches `TIMEOUT_CYCLES`, deassert `reg_valid_o` the next cycle and respond with SLVERR; read data = '0.
  - A `reg_ready_i` in the same cycle as the count hitting the limit wins: the response is normal.
- **RESP_B / RESP_R.** Hold `b_valid_o` / `r_valid_o` until `b_ready_i` / `r_ready_i`, then return to IDLE. Responses never change while valid.
- **Reset behaviour.**
  - Reset clears all holding flags and the counter, sets state IDLE and `last_was_write`=0, and drives every output to 0.
  - Reset mid-access abandons the access silently; no response is ever issued for it.

## Timing

- All outputs are registered.
- Handshakes complete on valid && ready at the rising edge.
- **Write latency.** AW and W accepted in cycle 0 → `reg_valid_o` in cycle 1. `reg_ready_i` in cycle k → `b_valid_o` in cycle k+1.
- **Read latency.** Same as writes, with `r_valid_o`.
- **AW and W in different cycles:** the access starts the cycle after the later of the two handshakes.
- **Ready during RESP.** The `*_ready_o` outputs are low during REG_*/RESP_*, so at most one transaction is outstanding. New AW/W/AR may be accepted in IDLE while the other class is being latched.
- **Best-case throughput:** one transaction every 3 cycles (IDLE → REG → RESP).
- **Timeout worst case:** `b_valid_o`/`r_valid_o` asserts `TIMEOUT_CYCLES`+1 cycles after the REG_* state is entered.

## Structure

- **Package `spi_bridge_pkg`:**
  - the `bridge_state_e` enum;
  - the `RESP_OKAY`/`RESP_SLVERR` constants;
  - a function computing the strobe width.
- **Sub-module `spi_bridge_timeout_cnt`:** parameter `MAX`; inputs `clear_i`, `en_i`; output `expired_o`. Counter width is `$clog2(MAX+1)`, saturating at `MAX`.
- Everything else (holding registers, FSM, arbitration flag) lives in the top module.

## Test plan

1. **Basic write.** AW addr 0x0000_0010 and W data 0xCAFE_F00D, strb 0xF, in the same cycle; target ready after 2 cycles.
   - `reg_*` shows the same addr/data/strb, write=1; `b_resp_o`=00 appears 1 cycle after ready.
2. **Read with error.** AR 0x0000_0020; target returns ready with rdata 0x1234_5678 and error=1.
   - `r_data_o`=0x1234_5678, `r_resp_o`=10.
3. **Simultaneous read and write, twice in a row** (AW+W+AR pending together, then again).
   - First contention serves the write; second serves the read (alternation).
4. **Timeout.** `TIMEOUT_CYCLES`=4; target never asserts ready.
   - `reg_valid_o` drops; SLVERR appears 5 cycles after entering REG; `r_data_o`=0 for a read.
5. **Zero strobe and split AW/W.**
   - W with strb 0x0: no `reg_valid_o` pulse, OKAY response.
   - AW 3 cycles before W: the access starts the cycle after the W handshake.
6. **Reset mid-access and back-pressure.**
   - `rst_i` pulsed during REG_RD: all outputs 0 the next cycle, no r response.
   - `b_ready_i` held low 10 cycles: `b_valid_o`/`b_resp_o` stay stable.

Source files
------------

// File: rtl/spi_axi_lite_reg_bridge_pkg.sv
// Shared types and constants for the AXI-lite to register-bus bridge.
package spi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REG_WR,
    REG_RD,
    RESP_B,
    RESP_R
  } bridge_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/spi_axi_lite_reg_bridge_if.sv
// AXI-lite slave channels plus the downstream register bus, bundled for the bridge.
interface spi_axi_lite_reg_bridge_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
);
  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  logic                      aw_valid_i;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_i;
  logic                      aw_ready_o;
  logic                      w_valid_i;
  logic [AXI_DATA_WIDTH-1:0] w_data_i;
  logic [STRB_W-1:0]         w_strb_i;
  logic                      w_ready_o;
  logic                      b_valid_o;
  logic [1:0]                b_resp_o;
  logic                      b_ready_i;
  logic                      ar_valid_i;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_i;
  logic                      ar_ready_o;
  logic                      r_valid_o;
  logic [AXI_DATA_WIDTH-1:0] r_data_o;
  logic [1:0]                r_resp_o;
  logic                      r_ready_i;

  logic                      reg_valid_o;
  logic                      reg_write_o;
  logic [AXI_ADDR_WIDTH-1:0] reg_addr_o;
  logic [AXI_DATA_WIDTH-1:0] reg_wdata_o;
  logic [STRB_W-1:0]         reg_wstrb_o;
  logic                      reg_ready_i;
  logic [AXI_DATA_WIDTH-1:0] reg_rdata_i;
  logic                      reg_error_i;

  // Bridge side: AXI-lite slave, register-bus master.
  modport slave (
    input  aw_valid_i, aw_addr_i, w_valid_i, w_data_i, w_strb_i, b_ready_i,
    input  ar_valid_i, ar_addr_i, r_ready_i,
    input  reg_ready_i, reg_rdata_i, reg_error_i,
    output aw_ready_o, w_ready_o, b_valid_o, b_resp_o,
    output ar_ready_o, r_valid_o, r_data_o, r_resp_o,
    output reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o
  );

  // Environment side: AXI-lite master and register target.
  modport master (
    output aw_valid_i, aw_addr_i, w_valid_i, w_data_i, w_strb_i, b_ready_i,
    output ar_valid_i, ar_addr_i, r_ready_i,
    output reg_ready_i, reg_rdata_i, reg_error_i,
    input  aw_ready_o, w_ready_o, b_valid_o, b_resp_o,
    input  ar_ready_o, r_valid_o, r_data_o, r_resp_o,
    input  reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o
  );

endinterface

// File: rtl/spi_axi_lite_reg_bridge_timeout_cnt.sv
// Saturating wait counter; expired_o flags that MAX idle cycles have elapsed.
module spi_bridge_timeout_cnt #(
  parameter int MAX = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == MAX_V);

endmodule

// File: rtl/spi_axi_lite_reg_bridge.sv
// Terminates AXI-lite and issues one register-bus access per transaction,
// alternating read/write priority and bounding every access with a timeout.
module spi_axi_lite_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk_i,
  input logic rst_i,
  spi_axi_lite_reg_bridge_if.slave bus
);
  localparam int STRB_W = strb_width(AXI_DATA_WIDTH);

  bridge_state_e state_q, state_d;
  logic aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
  logic last_wr_q, last_wr_d;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]         w_strb_q, w_strb_d;

  logic aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, ar_ready_q, ar_ready_d;
  logic b_valid_q, b_valid_d, r_valid_q, r_valid_d;
  logic [1:0] b_resp_q, b_resp_d, r_resp_q, r_resp_d;
  logic [AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic reg_valid_q, reg_valid_d, reg_write_q, reg_write_d;
  logic [AXI_ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [AXI_DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
  logic [STRB_W-1:0]         reg_wstrb_q, reg_wstrb_d;

  logic wr_pend, rd_pend, done, cnt_clear, cnt_en, expired;
  logic [1:0] resp;

  spi_bridge_timeout_cnt #(.MAX(TIMEOUT_CYCLES)) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (cnt_clear),
    .en_i     (cnt_en),
    .expired_o(expired)
  );

  always_comb begin
    state_d     = state_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    ar_held_d   = ar_held_q;
    last_wr_d   = last_wr_q;
    aw_addr_d   = aw_addr_q;
    ar_addr_d   = ar_addr_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    b_valid_d   = b_valid_q;
    b_resp_d    = b_resp_q;
    r_valid_d   = r_valid_q;
    r_resp_d    = r_resp_q;
    r_data_d    = r_data_q;
    reg_valid_d = reg_valid_q;
    reg_write_d = reg_write_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wstrb_d = reg_wstrb_q;
    wr_pend     = 1'b0;
    rd_pend     = 1'b0;
    done        = 1'b0;
    resp        = RESP_OKAY;
    cnt_clear   = 1'b1;
    cnt_en      = 1'b0;

    // Handshakes can only fire in IDLE since the registered readies are low elsewhere.
    if (bus.aw_valid_i && aw_ready_q) begin
      aw_held_d = 1'b1;
      aw_addr_d = bus.aw_addr_i;
    end
    if (bus.w_valid_i && w_ready_q) begin
      w_held_d = 1'b1;
      w_data_d = bus.w_data_i;
      w_strb_d = bus.w_strb_i;
    end
    if (bus.ar_valid_i && ar_ready_q) begin
      ar_held_d = 1'b1;
      ar_addr_d = bus.ar_addr_i;
    end

    case (state_q)
      IDLE: begin
        // Decide on the post-handshake view so an access starts the very next cycle.
        wr_pend = aw_held_d && w_held_d;
        rd_pend = ar_held_d;
        if (wr_pend && (!rd_pend || !last_wr_q)) begin
          last_wr_d = 1'b1;
          if (w_strb_d == '0) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            b_valid_d = 1'b1;
            b_resp_d  = RESP_OKAY;
            state_d   = RESP_B;
          end else begin
            reg_valid_d = 1'b1;
            reg_write_d = 1'b1;
            reg_addr_d  = aw_addr_d;
            reg_wdata_d = w_data_d;
            reg_wstrb_d = w_strb_d;
            state_d     = REG_WR;
          end
        end else if (rd_pend) begin
          last_wr_d   = 1'b0;
          reg_valid_d = 1'b1;
          reg_write_d = 1'b0;
          reg_addr_d  = ar_addr_d;
          reg_wdata_d = '0;
          reg_wstrb_d = '0;
          state_d     = REG_RD;
        end
      end
      REG_WR, REG_RD: begin
        cnt_clear = 1'b0;
        cnt_en    = !bus.reg_ready_i;
        done      = bus.reg_ready_i || expired;
        resp      = (bus.reg_ready_i && !bus.reg_error_i) ? RESP_OKAY : RESP_SLVERR;
        if (done) begin
          reg_valid_d = 1'b0;
          if (state_q == REG_WR) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            b_valid_d = 1'b1;
            b_resp_d  = resp;
            state_d   = RESP_B;
          end else begin
            ar_held_d = 1'b0;
            r_valid_d = 1'b1;
            r_resp_d  = resp;
            r_data_d  = bus.reg_ready_i ? bus.reg_rdata_i : '0;
            state_d   = RESP_R;
          end
        end
      end
      RESP_B: begin
        if (bus.b_ready_i) begin
          b_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      RESP_R: begin
        if (bus.r_ready_i) begin
          r_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    aw_ready_d = (state_d == IDLE) && !aw_held_d;
    w_ready_d  = (state_d == IDLE) && !w_held_d;
    ar_ready_d = (state_d == IDLE) && !ar_held_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      ar_held_q   <= 1'b0;
      last_wr_q   <= 1'b0;
      aw_addr_q   <= '0;
      ar_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      aw_ready_q  <= 1'b0;
      w_ready_q   <= 1'b0;
      ar_ready_q  <= 1'b0;
      b_valid_q   <= 1'b0;
      b_resp_q    <= '0;
      r_valid_q   <= 1'b0;
      r_resp_q    <= '0;
      r_data_q    <= '0;
      reg_valid_q <= 1'b0;
      reg_write_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      ar_held_q   <= ar_held_d;
      last_wr_q   <= last_wr_d;
      aw_addr_q   <= aw_addr_d;
      ar_addr_q   <= ar_addr_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      aw_ready_q  <= aw_ready_d;
      w_ready_q   <= w_ready_d;
      ar_ready_q  <= ar_ready_d;
      b_valid_q   <= b_valid_d;
      b_resp_q    <= b_resp_d;
      r_valid_q   <= r_valid_d;
      r_resp_q    <= r_resp_d;
      r_data_q    <= r_data_d;
      reg_valid_q <= reg_valid_d;
      reg_write_q <= reg_write_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wstrb_q <= reg_wstrb_d;
    end
  end

  assign bus.aw_ready_o  = aw_ready_q;
  assign bus.w_ready_o   = w_ready_q;
  assign bus.ar_ready_o  = ar_ready_q;
  assign bus.b_valid_o   = b_valid_q;
  assign bus.b_resp_o    = b_resp_q;
  assign bus.r_valid_o   = r_valid_q;
  assign bus.r_resp_o    = r_resp_q;
  assign bus.r_data_o    = r_data_q;
  assign bus.reg_valid_o = reg_valid_q;
  assign bus.reg_write_o = reg_write_q;
  assign bus.reg_addr_o  = reg_addr_q;
  assign bus.reg_wdata_o = reg_wdata_q;
  assign bus.reg_wstrb_o = reg_wstrb_q;

endmodule
